object_slot_scheduler: RTL



---
 rtl/object_slot_scheduler_pkg.sv | 16 +
 rtl/object_slot_scheduler_lowest_set_index.sv | 31 +++
 rtl/object_slot_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/object_slot_scheduler_pkg.sv
// Shared types and default constants for the object slot scheduler.
package object_slot_scheduler_pkg;

  // Scheduler FSM: waiting for a spawn, or holding a slot load handshake.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } sched_state_e;

  localparam int unsigned DEF_OBJECT_AMOUNT  = 8;
  localparam int unsigned DEF_IDX_W          = 5;
  localparam int unsigned DEF_DROP_WHEN_FULL = 0;
  localparam int unsigned DEF_LOAD_TIMEOUT   = 64;
  localparam int unsigned DROP_CNT_W         = 8;

endpackage

// File: rtl/object_slot_scheduler_lowest_set_index.sv
// Priority encoder: reports whether any bit of vec_i is set and the lowest set index.
// Ports:
//   vec_i    N-bit input vector
//   found_o  1 when any bit of vec_i is set
//   idx_o    lowest set index, zero-extended to IDX_W; 0 when none set
module lowest_set_index
  import object_slot_scheduler_pkg::*;
#(
  parameter int unsigned N     = DEF_OBJECT_AMOUNT,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic [N-1:0]     vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan upward; the first set bit wins.
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i] && !found) begin
        found = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/object_slot_scheduler.sv
// Object slot scheduler: hands free object-controller slots to spawn requests,
// runs the per-slot load handshake with timeout, and merges render hits.
// Ports:
//   clk_calculation, reset      clock, synchronous active-high reset
//   spawn_valid_i/spawn_ready_o spawn handshake from the pattern ROM sequencer
//   spawn_done_o                pulse: descriptor captured by a slot
//   spawn_dropped_o             pulse: spawn discarded (full in drop mode, or timeout)
//   load_timeout_o              pulse: slot did not ack in time
//   slot_load_o/slot_load_ack_i one-hot load level and per-slot ack
//   slot_free_i                 per-slot object destroyed/idle
//   slot_render_i               per-slot renderer hit for the current pixel
//   busy_mask_o, active_count_o, slots_full_o, drop_count_o  status
//   object_signal_o, hit_valid_o, hit_index_o               merged render hit
module object_slot_scheduler
  import object_slot_scheduler_pkg::*;
#(
  parameter int unsigned OBJECT_AMOUNT  = DEF_OBJECT_AMOUNT,
  parameter int unsigned IDX_W          = DEF_IDX_W,
  parameter int unsigned DROP_WHEN_FULL = DEF_DROP_WHEN_FULL,
  parameter int unsigned LOAD_TIMEOUT   = DEF_LOAD_TIMEOUT
) (
  input  logic                     clk_calculation,
  input  logic                     reset,
  input  logic                     spawn_valid_i,
  output logic                     spawn_ready_o,
  output logic                     spawn_done_o,
  output logic                     spawn_dropped_o,
  output logic                     load_timeout_o,
  output logic [OBJECT_AMOUNT-1:0] slot_load_o,
  input  logic [OBJECT_AMOUNT-1:0] slot_load_ack_i,
  input  logic [OBJECT_AMOUNT-1:0] slot_free_i,
  input  logic [OBJECT_AMOUNT-1:0] slot_render_i,
  output logic [OBJECT_AMOUNT-1:0] busy_mask_o,
  output logic [IDX_W:0]           active_count_o,
  output logic                     slots_full_o,
  output logic [DROP_CNT_W-1:0]    drop_count_o,
  output logic                     object_signal_o,
  output logic                     hit_valid_o,
  output logic [IDX_W-1:0]         hit_index_o
);

  localparam int unsigned N     = OBJECT_AMOUNT;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMR_W = $clog2(LOAD_TIMEOUT) + 1;
  // Timer value in the last LOAD cycle: the increment would reach LOAD_TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOAD_TIMEOUT - 2);
  localparam logic [N-1:0]     ONE       = N'(1);
  localparam logic             DROP_MODE = (DROP_WHEN_FULL != 0);

  sched_state_e          state_q, state_d;
  logic [N-1:0]          busy_q, busy_d;
  logic [N-1:0]          load_q, load_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  done_q, done_d;
  logic                  dropped_q, dropped_d;
  logic                  tmo_q, tmo_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]      active_q, active_d;
  logic                  full_q, full_d;

  logic                  alloc_found;
  logic [IDX_W-1:0]      alloc_idx;
  logic                  hit_found;
  logic [IDX_W-1:0]      hit_idx;
  logic                  accept;

  // Lowest free slot for allocation.
  lowest_set_index #(.N(N), .IDX_W(IDX_W)) u_alloc (
    .vec_i   (~busy_q),
    .found_o (alloc_found),
    .idx_o   (alloc_idx)
  );

  // Lowest rendering slot wins the pixel.
  lowest_set_index #(.N(N), .IDX_W(IDX_W)) u_hit (
    .vec_i   (slot_render_i),
    .found_o (hit_found),
    .idx_o   (hit_idx)
  );

  // Ready tracks busy_mask directly so a freed slot is usable the next cycle.
  assign spawn_ready_o = (state_q == ST_IDLE) && (alloc_found || DROP_MODE);
  assign accept        = spawn_valid_i && spawn_ready_o;

  // Next-state and output logic.
  always_comb begin
    logic drop_evt;
    state_d    = state_q;
    // load_q is the one-hot selected slot during LOAD (zero in IDLE), which
    // shields the slot being loaded from a stale free.
    busy_d     = busy_q & ~(slot_free_i & ~load_q);
    load_d     = load_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;
    tmo_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    full_d     = &busy_q;
    active_d   = '0;
    drop_evt   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      active_d = active_d + CNT_W'(busy_q[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alloc_found) begin
            // Allocation is applied after the free so it wins on a collision.
            busy_d  = busy_d | (ONE << alloc_idx);
            load_d  = ONE << alloc_idx;
            timer_d = '0;
            state_d = ST_LOAD;
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        timer_d = timer_q + TMR_W'(1);
        if (|(slot_load_ack_i & load_q)) begin
          load_d  = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          busy_d   = busy_d & ~load_q;
          load_d   = '0;
          tmo_d    = 1'b1;
          drop_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_evt) begin
      dropped_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      load_q     <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      tmo_q      <= 1'b0;
      drop_cnt_q <= '0;
      active_q   <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
      tmo_q      <= tmo_d;
      drop_cnt_q <= drop_cnt_d;
      active_q   <= active_d;
      full_q     <= full_d;
    end
  end

  assign spawn_done_o    = done_q;
  assign spawn_dropped_o = dropped_q;
  assign load_timeout_o  = tmo_q;
  assign slot_load_o     = load_q;
  assign busy_mask_o     = busy_q;
  assign active_count_o  = active_q;
  assign slots_full_o    = full_q;
  assign drop_count_o    = drop_cnt_q;
  assign object_signal_o = hit_found;
  assign hit_valid_o     = hit_found;
  assign hit_index_o     = hit_idx;

endmodule
